// File: rtl/regfile_wr_arbiter.sv
// Single write port sequencer for the LC-3 register file: round-robin between two requesters plus a bulk-init walk.
// Ready is combinational; accepted writes appear on the registered LD_REG/DR_out/Data_out one cycle later.
module regfile_wr_arbiter #(
   parameter  int DATA_W = 16,
   parameter  int NREG   = 8,
   localparam int AW     = $clog2(NREG)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req0_valid,
   input  logic [AW-1:0]     req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [AW-1:0]     req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              init_start,
   input  logic [DATA_W-1:0] init_data,
   output logic              init_busy,
   output logic              init_done,
   output logic              LD_REG,
   output logic [AW-1:0]     DR_out,
   output logic [DATA_W-1:0] Data_out,
   output logic              last_grant
);

   typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_t;

   localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

   state_t              state_q, state_d;
   logic [AW-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]   ival_q, ival_d;
   logic                ld_q, ld_d;
   logic [AW-1:0]       dr_q, dr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                done_q, done_d;
   logic                lg_q, lg_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ival_q  <= '0;
         ld_q    <= 1'b0;
         dr_q    <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         lg_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ival_q  <= ival_d;
         ld_q    <= ld_d;
         dr_q    <= dr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         lg_q    <= lg_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ival_d     = ival_q;
      ld_d       = 1'b0;
      dr_d       = dr_q;
      data_d     = data_q;
      done_d     = 1'b0;
      lg_d       = lg_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (init_start) begin
               // R0 is issued on the accepting edge so the eight writes line up with the busy window
               state_d = INIT;
               ival_d  = init_data;
               ld_d    = 1'b1;
               dr_d    = '0;
               data_d  = init_data;
               cnt_d   = AW'(1);
            end else begin
               req0_ready = req0_valid & (~req1_valid | lg_q);
               req1_ready = req1_valid & (~req0_valid | ~lg_q);
               if (req0_ready) begin
                  ld_d   = 1'b1;
                  dr_d   = req0_addr;
                  data_d = req0_data;
                  lg_d   = 1'b0;
               end else if (req1_ready) begin
                  ld_d   = 1'b1;
                  dr_d   = req1_addr;
                  data_d = req1_data;
                  lg_d   = 1'b1;
               end
            end
         end
         INIT: begin
            // counter back at zero means R7 is already on the outputs: hold INIT one last cycle
            if (cnt_q != '0) begin
               ld_d   = 1'b1;
               dr_d   = cnt_q;
               data_d = ival_q;
               done_d = (cnt_q == LAST_REG);
               cnt_d  = (cnt_q == LAST_REG) ? '0 : cnt_q + AW'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign init_busy  = (state_q == INIT);
   assign init_done  = done_q;
   assign LD_REG     = ld_q;
   assign DR_out     = dr_q;
   assign Data_out   = data_q;
   assign last_grant = lg_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: inputs driven 1ns after the rising edge, outputs sampled before the next one.
module tb_regfile_wr_arbiter;

   logic        Clk;
   logic        Reset;
   logic        req0_valid, req1_valid;
   logic [2:0]  req0_addr, req1_addr;
   logic [15:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        init_start;
   logic [15:0] init_data;
   logic        init_busy, init_done;
   logic        LD_REG;
   logic [2:0]  DR_out;
   logic [15:0] Data_out;
   logic        last_grant;

   int checks = 0;
   int errors = 0;

   regfile_wr_arbiter dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .init_start (init_start),
      .init_data  (init_data),
      .init_busy  (init_busy),
      .init_done  (init_done),
      .LD_REG     (LD_REG),
      .DR_out     (DR_out),
      .Data_out   (Data_out),
      .last_grant (last_grant)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_ld"},   32'(LD_REG),     32'd0);
      chk({tag, "_dr"},   32'(DR_out),     32'd0);
      chk({tag, "_data"}, 32'(Data_out),   32'd0);
      chk({tag, "_busy"}, 32'(init_busy),  32'd0);
      chk({tag, "_done"}, 32'(init_done),  32'd0);
      chk({tag, "_lg"},   32'(last_grant), 32'd1);
   endtask

   initial begin
      Reset = 1'b1;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      init_start = 1'b0; init_data = '0;
      #3;
      chk_idle_outs("rst");
      next_cycle();
      next_cycle();
      Reset = 1'b0;

      // single write from req0
      req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'hBEEF;
      #1;
      chk("w0_rdy0", 32'(req0_ready), 32'd1);
      chk("w0_rdy1", 32'(req1_ready), 32'd0);
      next_cycle();
      req0_valid = 1'b0;
      chk("w0_ld",   32'(LD_REG),     32'd1);
      chk("w0_dr",   32'(DR_out),     32'd3);
      chk("w0_data", 32'(Data_out),   32'hBEEF);
      chk("w0_lg",   32'(last_grant), 32'd0);
      next_cycle();
      chk("w0_ld_off",    32'(LD_REG),   32'd0);
      chk("w0_dr_hold",   32'(DR_out),   32'd3);
      chk("w0_data_hold", 32'(Data_out), 32'hBEEF);

      // single write from req1, leaving last_grant=1
      req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 16'h0606;
      #1;
      chk("w1_rdy1", 32'(req1_ready), 32'd1);
      next_cycle();
      req1_valid = 1'b0;
      chk("w1_ld",   32'(LD_REG),     32'd1);
      chk("w1_dr",   32'(DR_out),     32'd6);
      chk("w1_data", 32'(Data_out),   32'h0606);
      chk("w1_lg",   32'(last_grant), 32'd1);
      next_cycle();

      // contention: grants alternate 0,1,0,1
      req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h1111;
      req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h2222;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("ct_rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("ct_rdy1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         next_cycle();
         if (i == 3) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         chk("ct_ld",   32'(LD_REG),     32'd1);
         chk("ct_dr",   32'(DR_out),     (i % 2 == 0) ? 32'd1 : 32'd2);
         chk("ct_data", 32'(Data_out),   (i % 2 == 0) ? 32'h1111 : 32'h2222);
         chk("ct_lg",   32'(last_grant), (i % 2 == 0) ? 32'd0 : 32'd1);
      end
      next_cycle();
      chk("ct_ld_off", 32'(LD_REG), 32'd0);

      // bulk init with a competing req0 in the start cycle
      init_start = 1'b1; init_data = 16'h00A5;
      req0_valid = 1'b1; req0_addr = 3'd4; req0_data = 16'h4444;
      #1;
      chk("in_rdy0_t",  32'(req0_ready), 32'd0);
      chk("in_busy_t",  32'(init_busy),  32'd0);
      next_cycle();
      init_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("in_busy", 32'(init_busy),  32'd1);
         chk("in_ld",   32'(LD_REG),     32'd1);
         chk("in_dr",   32'(DR_out),     32'(k));
         chk("in_data", 32'(Data_out),   32'h00A5);
         chk("in_done", 32'(init_done),  (k == 7) ? 32'd1 : 32'd0);
         chk("in_rdy0", 32'(req0_ready), 32'd0);
         next_cycle();
      end
      chk("in_busy_end", 32'(init_busy),  32'd0);
      chk("in_ld_end",   32'(LD_REG),     32'd0);
      chk("in_done_end", 32'(init_done),  32'd0);
      chk("in_rdy0_end", 32'(req0_ready), 32'd1);
      chk("in_lg_kept",  32'(last_grant), 32'd1);
      next_cycle();
      req0_valid = 1'b0;
      chk("pi_ld",   32'(LD_REG),     32'd1);
      chk("pi_dr",   32'(DR_out),     32'd4);
      chk("pi_data", 32'(Data_out),   32'h4444);
      chk("pi_lg",   32'(last_grant), 32'd0);
      next_cycle();

      // reset mid-init once R4 is on the outputs
      init_start = 1'b1; init_data = 16'h1234;
      next_cycle();
      init_start = 1'b0;
      next_cycle();
      next_cycle();
      next_cycle();
      next_cycle();
      chk("ab_dr4", 32'(DR_out), 32'd4);
      #2;
      Reset = 1'b1;
      #1;
      chk_idle_outs("ab_rst");
      next_cycle();
      Reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("ab_ld",   32'(LD_REG),    32'd0);
         chk("ab_busy", 32'(init_busy), 32'd0);
         next_cycle();
      end
      req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 16'h7777;
      #1;
      chk("ab_rdy1", 32'(req1_ready), 32'd1);
      next_cycle();
      req1_valid = 1'b0;
      chk("ab_w_dr",   32'(DR_out),   32'd7);
      chk("ab_w_data", 32'(Data_out), 32'h7777);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
